csr_file_m: RTL and testbench

Parametrised machine-mode CSR file for the single-issue core. It is the successor of the fixed four-register CSR block and adds the following:
- read-modify-write CSR ops
- full trap entry and mret state updates on mstatus
- vectored mtvec
- mscratch
- 64-bit mcycle/minstret counters
- read-only ID CSRs
- illegal-access flagging

It sits beside the register file and is driven by the decode/execute stage. It supplies the trap/return redirect target to the PC logic.

---
 rtl/csr_file_m.sv | 215 +++++++++++++++++++++
 tb/tb_csr_file_m.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file for the single-issue core.
// Provides mstatus (MIE/MPIE, MPP fixed at 11), mtvec (direct/vectored),
// mscratch, mepc, mcause, 64-bit mcycle/minstret counters, and read-only
// mvendorid/mhartid. It handles CSRRW/CSRRS/CSRRC read-modify-write, trap entry
// and mret, and flags illegal accesses.
// Ports:
//   clk, rst_n          core clock (rising edge), asynchronous active-low reset
//   pc                  PC of the instruction in execute (recorded into mepc on a trap)
//   csr_addr, csr_op    CSR address; op 00 none, 01 write, 10 set, 11 clear
//   csr_wdata           rs1 value or zero-extended uimm
//   csr_valid           the instruction in execute is a CSR instruction
//   trap_valid          take a trap this cycle, with mcause value trap_cause
//   mret_valid          execute mret this cycle
//   instret             one instruction retires this cycle
//   r_csr_data          combinational read of csr_addr (value before this cycle's update)
//   redirect_pc         trap or mret target for the PC logic
//   illegal_csr         unknown address, or a real write to a read-only CSR
//   mie_out             current mstatus.MIE
module csr_file_m #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] MSTATUS_RST  = 32'h0000_1800,
  parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
  parameter logic [31:0] HART_ID      = 32'h0000_0000,
  parameter logic [31:0] VENDOR_ID    = 32'h0000_0000,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_valid,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_valid,
  input  logic            instret,
  output logic [XLEN-1:0] r_csr_data,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_csr,
  output logic            mie_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        mie_r;
  logic        mpie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic [31:0] mstatus_s;
  logic [31:0] rdata_s;
  logic        known_s;
  logic        ro_s;
  logic        write_req_s;
  logic        illegal_s;
  logic        do_write_s;
  logic [31:0] new_s;
  logic [31:0] trap_base_s;
  logic [31:0] redirect_s;

  // Only MIE and MPIE are stored; MPP reads back as the fixed value 11.
  assign mstatus_s = {19'd0, 2'b11, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};

  // Read mux plus address decode (known / read-only).
  always_comb begin
    rdata_s = 32'd0;
    known_s = 1'b0;
    ro_s    = 1'b0;
    case (csr_addr)
      A_MSTATUS:   begin rdata_s = mstatus_s;  known_s = 1'b1; end
      A_MTVEC:     begin rdata_s = mtvec_r;    known_s = 1'b1; end
      A_MSCRATCH:  begin rdata_s = mscratch_r; known_s = 1'b1; end
      A_MEPC:      begin rdata_s = mepc_r;     known_s = 1'b1; end
      A_MCAUSE:    begin rdata_s = mcause_r;   known_s = 1'b1; end
      A_MVENDORID: begin rdata_s = VENDOR_ID;  known_s = 1'b1; ro_s = 1'b1; end
      A_MHARTID:   begin rdata_s = HART_ID;    known_s = 1'b1; ro_s = 1'b1; end
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: begin
        // Counter addresses only exist when the counters are built in.
        if (HAS_COUNTERS) begin
          known_s = 1'b1;
          case (csr_addr)
            A_MCYCLE:    rdata_s = mcycle_r[31:0];
            A_MCYCLEH:   rdata_s = mcycle_r[63:32];
            A_MINSTRET:  rdata_s = minstret_r[31:0];
            default:     rdata_s = minstret_r[63:32];
          endcase
        end else begin
          known_s = 1'b0;
          rdata_s = 32'd0;
        end
      end
      default: begin
        rdata_s = 32'd0;
        known_s = 1'b0;
      end
    endcase
  end

  // Set/clear with a zero mask is a pure read, so it is not a write to an RO CSR.
  assign write_req_s = csr_valid & ((csr_op == 2'b01) | (csr_op[1] & (csr_wdata != 32'd0)));
  assign illegal_s   = csr_valid & (~known_s | (ro_s & write_req_s));
  assign do_write_s  = write_req_s & ~illegal_s & ~trap_valid & ~mret_valid;

  // Read-modify-write value from the pre-update CSR contents.
  always_comb begin
    case (csr_op)
      2'b01:   new_s = csr_wdata;
      2'b10:   new_s = rdata_s | csr_wdata;
      2'b11:   new_s = rdata_s & ~csr_wdata;
      default: new_s = rdata_s;
    endcase
  end

  assign trap_base_s = mtvec_r & 32'hFFFF_FFFC;

  // Redirect target: trap beats mret; vectored only for interrupts.
  always_comb begin
    if (trap_valid) begin
      if ((mtvec_r[1:0] == 2'b01) && trap_cause[31]) begin
        // Shift drops cause bit 31 and wraps 4*cause[30:0] to 32 bits.
        redirect_s = trap_base_s + (trap_cause << 2);
      end else begin
        redirect_s = trap_base_s;
      end
    end else if (mret_valid) begin
      redirect_s = mepc_r;
    end else begin
      redirect_s = 32'd0;
    end
  end

  assign r_csr_data  = rdata_s;
  assign redirect_pc = redirect_s;
  assign illegal_csr = illegal_s;
  assign mie_out     = mie_r;

  // Architectural CSR state: trap entry, mret, then software writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_r      <= MSTATUS_RST[3];
      mpie_r     <= MSTATUS_RST[7];
      mtvec_r    <= MTVEC_RST;
      mscratch_r <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
    end else if (trap_valid) begin
      mepc_r   <= pc & 32'hFFFF_FFFC;
      mcause_r <= trap_cause;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (mret_valid) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (do_write_s) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_r  <= new_s[3];
          mpie_r <= new_s[7];
        end
        // Reserved modes 1x leave the mode field as it was; the base still updates.
        A_MTVEC:    mtvec_r    <= {new_s[31:2], (new_s[1] ? mtvec_r[1:0] : new_s[1:0])};
        A_MSCRATCH: mscratch_r <= new_s;
        A_MEPC:     mepc_r     <= new_s & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause_r   <= new_s;
        default:    mscratch_r <= mscratch_r;
      endcase
    end else begin
      mscratch_r <= mscratch_r;
    end
  end

  // Counters: a write to one half replaces the increment; the other half holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else if (HAS_COUNTERS) begin
      if (do_write_s && (csr_addr == A_MCYCLE)) begin
        mcycle_r[31:0] <= new_s;
      end else if (do_write_s && (csr_addr == A_MCYCLEH)) begin
        mcycle_r[63:32] <= new_s;
      end else begin
        mcycle_r <= mcycle_r + 64'd1;
      end
      if (do_write_s && (csr_addr == A_MINSTRET)) begin
        minstret_r[31:0] <= new_s;
      end else if (do_write_s && (csr_addr == A_MINSTRETH)) begin
        minstret_r[63:32] <= new_s;
      end else if (instret) begin
        minstret_r <= minstret_r + 64'd1;
      end else begin
        minstret_r <= minstret_r;
      end
    end else begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: expected values are queued when stimulus
// is applied and compared against DUT outputs as they are sampled.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = 32'd0;
  logic [11:0] csr_addr = 12'd0;
  logic [1:0]  csr_op = 2'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic        csr_valid = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = 32'd0;
  logic        mret_valid = 1'b0;
  logic        instret = 1'b0;
  logic [31:0] r_csr_data;
  logic [31:0] redirect_pc;
  logic        illegal_csr;
  logic        mie_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  csr_file_m dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_valid(csr_valid), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .mret_valid(mret_valid), .instret(instret),
    .r_csr_data(r_csr_data), .redirect_pc(redirect_pc),
    .illegal_csr(illegal_csr), .mie_out(mie_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a CSR combinationally (no CSR instruction active).
  task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
    csr_addr = addr;
    push_exp(tag, exp);
    #1;
    pop_check(r_csr_data);
  endtask

  task automatic chk_illegal(input string tag, input logic exp);
    push_exp(tag, {31'd0, exp});
    #1;
    pop_check({31'd0, illegal_csr});
  endtask

  task automatic chk_mie(input string tag, input logic exp);
    push_exp(tag, {31'd0, exp});
    #1;
    pop_check({31'd0, mie_out});
  endtask

  task automatic chk_redirect(input string tag, input logic [31:0] exp);
    push_exp(tag, exp);
    #1;
    pop_check(redirect_pc);
  endtask

  task automatic csr_drive(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
    csr_valid = 1'b1;
    csr_addr  = addr;
    csr_op    = op;
    csr_wdata = wd;
  endtask

  task automatic csr_idle();
    csr_valid = 1'b0;
    csr_op    = 2'd0;
    csr_wdata = 32'd0;
  endtask

  task automatic csr_do(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
    csr_drive(addr, op, wd);
    tick();
    csr_idle();
  endtask

  // Trap for one cycle, checking the same-cycle redirect target.
  task automatic trap_do(input logic [31:0] tpc, input logic [31:0] cause,
                         input string tag, input logic [31:0] exp_redirect);
    pc         = tpc;
    trap_cause = cause;
    trap_valid = 1'b1;
    chk_redirect(tag, exp_redirect);
    tick();
    trap_valid = 1'b0;
  endtask

  initial begin
    // 1: reset values
    #1 rst_n = 1'b0;
    rd(12'h300, "rst_mstatus_in_reset", 32'h0000_1800);
    rd(12'hB00, "rst_mcycle_in_reset", 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(12'h300, "rst_mstatus", 32'h0000_1800);
    rd(12'h305, "rst_mtvec", 32'd0);
    rd(12'h341, "rst_mepc", 32'd0);
    rd(12'h342, "rst_mcause", 32'd0);
    chk_mie("rst_mie", 1'b0);
    chk_redirect("rst_redirect", 32'd0);

    // 2: vectored mtvec
    csr_do(12'h305, 2'b01, 32'h8000_0001);
    rd(12'h305, "mtvec_written", 32'h8000_0001);
    trap_do(32'h0000_0100, 32'h8000_0007, "redir_vectored_irq", 32'h8000_001C);
    trap_do(32'h0000_0100, 32'h0000_000B, "redir_sync_exc", 32'h8000_0000);
    rd(12'h342, "mcause_after_trap", 32'h0000_000B);

    // 3: trap entry and mret
    csr_do(12'h300, 2'b10, 32'h0000_0008);
    rd(12'h300, "mstatus_set_mie", 32'h0000_1808);
    chk_mie("mie_set", 1'b1);
    trap_do(32'h8000_0102, 32'h0000_0003, "redir_sync_vectored_mode", 32'h8000_0000);
    rd(12'h341, "mepc_trap", 32'h8000_0100);
    rd(12'h342, "mcause_trap", 32'h0000_0003);
    rd(12'h300, "mstatus_trap", 32'h0000_1880);
    chk_mie("mie_after_trap", 1'b0);
    mret_valid = 1'b1;
    chk_redirect("redir_mret", 32'h8000_0100);
    tick();
    mret_valid = 1'b0;
    rd(12'h300, "mstatus_mret", 32'h0000_1888);
    chk_mie("mie_after_mret", 1'b1);

    // 4: RMW ops, field masking, illegal accesses
    csr_do(12'h342, 2'b01, 32'h0000_000B);
    csr_drive(12'h342, 2'b11, 32'h0000_000F);
    chk_illegal("legal_csrrc", 1'b0);
    tick();
    csr_idle();
    rd(12'h342, "mcause_cleared", 32'd0);
    csr_do(12'h341, 2'b01, 32'h1234_5677);
    rd(12'h341, "mepc_low_bits", 32'h1234_5674);
    csr_do(12'h305, 2'b01, 32'h0000_0402);
    rd(12'h305, "mtvec_reserved_mode", 32'h0000_0401);
    csr_do(12'h300, 2'b01, 32'hFFFF_FFFF);
    rd(12'h300, "mstatus_mask", 32'h0000_1888);
    csr_do(12'h300, 2'b01, 32'd0);
    rd(12'h300, "mstatus_clear", 32'h0000_1800);
    csr_drive(12'hF14, 2'b01, 32'd5);
    chk_illegal("illegal_write_hartid", 1'b1);
    tick();
    csr_idle();
    rd(12'hF14, "hartid_unchanged", 32'd0);
    csr_drive(12'hF14, 2'b10, 32'd0);
    chk_illegal("legal_csrrs_zero_ro", 1'b0);
    tick();
    csr_drive(12'hF11, 2'b10, 32'd1);
    chk_illegal("illegal_set_vendorid", 1'b1);
    tick();
    csr_drive(12'h7C0, 2'b00, 32'd0);
    chk_illegal("illegal_unknown_addr", 1'b1);
    rd(12'h7C0, "unknown_reads_zero", 32'd0);
    tick();
    csr_idle();
    chk_illegal("no_access_not_illegal", 1'b0);

    // 5: counters
    csr_do(12'hB80, 2'b01, 32'h0000_0005);
    csr_do(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00, "mcycle_written", 32'hFFFF_FFFF);
    rd(12'hB80, "mcycleh_no_carry", 32'h0000_0005);
    tick();
    rd(12'hB00, "mcycle_wrapped", 32'd0);
    rd(12'hB80, "mcycleh_carry", 32'h0000_0006);
    csr_do(12'hB02, 2'b01, 32'd0);
    csr_do(12'hB82, 2'b01, 32'd0);
    instret = 1'b1;
    repeat (3) tick();
    instret = 1'b0;
    rd(12'hB02, "minstret_3", 32'd3);
    rd(12'hB82, "minstreth_0", 32'd0);

    // 6: priority and async reset
    csr_do(12'h340, 2'b01, 32'h0000_AAAA);
    csr_do(12'h300, 2'b01, 32'h0000_0080);
    rd(12'h340, "mscratch_written", 32'h0000_AAAA);
    mret_valid = 1'b1;
    csr_drive(12'h340, 2'b01, 32'h0000_1234);
    trap_do(32'h0000_0200, 32'h8000_0002, "redir_trap_priority", 32'h0000_0408);
    mret_valid = 1'b0;
    csr_idle();
    rd(12'h340, "mscratch_write_dropped", 32'h0000_AAAA);
    rd(12'h341, "mepc_trap_priority", 32'h0000_0200);
    rd(12'h300, "mstatus_trap_priority", 32'h0000_1800);
    csr_do(12'h300, 2'b10, 32'h0000_0008);
    @(posedge clk);
    #3 rst_n = 1'b0;
    rd(12'h340, "async_rst_mscratch", 32'd0);
    rd(12'h300, "async_rst_mstatus", 32'h0000_1800);
    rd(12'h305, "async_rst_mtvec", 32'd0);
    rd(12'h341, "async_rst_mepc", 32'd0);
    rd(12'hB80, "async_rst_mcycleh", 32'd0);
    rd(12'hB02, "async_rst_minstret", 32'd0);
    chk_mie("async_rst_mie", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
